// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send and
// shifts one command byte out on the device-generated clock, then collects the ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       timeout_o,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       ps2clk_drive_o,
  output logic       ps2data_drive_o
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_dataSync;
  logic                   r_clkPrev;
  logic [7:0]             r_byte;
  logic                   r_parity;
  logic [3:0]             r_bitCnt;
  logic [INH_W-1:0]       r_inhCnt;
  logic [TO_W-1:0]        r_toCnt;
  logic                   r_ack;
  logic                   r_clkDrive;
  logic                   r_dataDrive;
  logic                   r_done;
  logic                   r_ackErr;
  logic                   r_timeout;

  logic                   w_clkS;
  logic                   w_dataS;
  logic                   w_fall;
  logic [3:0]             w_nextN;

  assign w_clkS  = r_clkSync[SYNC_STAGES-1];
  assign w_dataS = r_dataSync[SYNC_STAGES-1];
  assign w_fall  = r_clkPrev & ~w_clkS;
  assign w_nextN = r_bitCnt + 4'd1;

  // Idle bus reads high, so the synchronizers reset to 1 to avoid a false fall.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_clkSync  <= '1;
      r_dataSync <= '1;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], ps2clk_i};
      r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], ps2data_i};
      r_clkPrev  <= w_clkS;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_byte      <= 8'h00;
      r_parity    <= 1'b0;
      r_bitCnt    <= 4'd0;
      r_inhCnt    <= '0;
      r_toCnt     <= '0;
      r_ack       <= 1'b0;
      r_clkDrive  <= 1'b0;
      r_dataDrive <= 1'b0;
      r_done      <= 1'b0;
      r_ackErr    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_ackErr  <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid_i && tx_ready_o) begin
            r_byte     <= tx_data_i;
            r_parity   <= ~^tx_data_i;
            r_inhCnt   <= '0;
            r_clkDrive <= 1'b1;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_inhCnt == INH_LAST) begin
            r_dataDrive <= 1'b1;
            r_state     <= S_REQ;
          end else begin
            r_inhCnt <= r_inhCnt + INH_W'(1);
          end
        end
        S_REQ: begin
          r_clkDrive <= 1'b0;
          r_bitCnt   <= 4'd0;
          r_toCnt    <= '0;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_toCnt  <= '0;
            r_bitCnt <= w_nextN;
            if (w_nextN <= 4'd8) begin
              r_dataDrive <= ~r_byte[r_bitCnt[2:0]];
            end else if (w_nextN == 4'd9) begin
              r_dataDrive <= ~r_parity;
            end else if (w_nextN == 4'd10) begin
              r_dataDrive <= 1'b0;
            end else begin
              r_ack   <= ~w_dataS;
              r_state <= S_WAIT_IDLE;
            end
          end else if (r_toCnt == TO_LAST) begin
            r_clkDrive  <= 1'b0;
            r_dataDrive <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (w_clkS && w_dataS) begin
            r_done   <= 1'b1;
            r_ackErr <= ~r_ack;
            r_state  <= S_IDLE;
          end else if (r_toCnt == TO_LAST) begin
            r_clkDrive  <= 1'b0;
            r_dataDrive <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready is held off during the done/timeout pulse so a waiting requester gets a one-cycle gap.
  assign tx_ready_o      = (r_state == S_IDLE) && !r_done && !r_timeout;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign ack_err_o       = r_ackErr;
  assign timeout_o       = r_timeout;
  assign ps2clk_drive_o  = r_clkDrive;
  assign ps2data_drive_o = r_dataDrive;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device that clocks
// the bus, samples each host bit on the rising edge and optionally acks.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady, busy, done, ackErr, tmo;
  logic       clkDrive, dataDrive;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic       ps2Clk, ps2Data;

  assign ps2Clk  = ~(clkDrive | devClkLow);
  assign ps2Data = ~(dataDrive | devDataLow);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rstN),
    .tx_data_i(txData),
    .tx_valid_i(txValid),
    .tx_ready_o(txReady),
    .busy_o(busy),
    .done_o(done),
    .ack_err_o(ackErr),
    .timeout_o(tmo),
    .ps2clk_i(ps2Clk),
    .ps2data_i(ps2Data),
    .ps2clk_drive_o(clkDrive),
    .ps2data_drive_o(dataDrive)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int errSolo = 0;
  int lastDoneCyc = -1;

  always @(posedge clk) cyc++;

  // Pulse monitor; ack_err without done in the same cycle is itself an error.
  always @(negedge clk) begin
    if (done) begin
      doneCnt++;
      lastDoneCyc = cyc;
    end
    if (ackErr) begin
      errCnt++;
      if (!done) errSolo++;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         ackLow;
    logic [9:0] expBits;
    int         expErr;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitClkRise(output int riseCyc);
    bit found = 0;
    riseCyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clkDrive) begin
        found = 1;
        riseCyc = cyc;
        break;
      end
    end
    if (!found) checkOutput("clkDriveRise", 0, 1);
  endtask

  task automatic startFrame(input logic [7:0] b);
    int riseCyc;
    txData  = b;
    txValid = 1'b1;
    waitClkRise(riseCyc);
  endtask

  task automatic measureInhibit(input bit keepValid, input logic [7:0] nextData,
                                output int inh, output int req);
    if (keepValid) txData = nextData;
    else txValid = 1'b0;
    inh = 0;
    req = 0;
    for (int i = 0; i < 4 * INH && clkDrive; i++) begin
      if (dataDrive) req++;
      else inh++;
      @(negedge clk);
    end
  endtask

  // Device clocks 11 falls; returns right after the 11th rising edge or after
  // the low phase of fall abortFall (clock left low for the caller).
  task automatic deviceClock(input bit ackLow, input int abortFall, output logic [9:0] bits);
    bit started = 0;
    bits = '0;
    for (int i = 0; i < 20; i++) begin
      if (ps2Clk && !ps2Data) begin
        started = 1;
        break;
      end
      @(negedge clk);
    end
    if (!started) begin
      checkOutput("startBit", 0, 1);
      return;
    end
    repeat (HALF) @(negedge clk);
    for (int n = 1; n <= 11; n++) begin
      devClkLow = 1'b1;
      repeat (HALF) @(negedge clk);
      if (n == abortFall) return;
      if (n <= 10) bits[n-1] = ps2Data;
      devClkLow = 1'b0;
      if (n == 10) devDataLow = ackLow;
      if (n == 11) devDataLow = 1'b0;
      if (n < 11) repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit ackLow,
                               output logic [9:0] bits, output int inh, output int req);
    startFrame(b);
    measureInhibit(0, 8'h00, inh, req);
    deviceClock(ackLow, 0, bits);
  endtask

  initial begin
    logic [9:0] bits;
    int inh, req, d0, e0, cnt, riseCyc;

    vecs[0] = '{data: 8'hED, ackLow: 1'b1, expBits: 10'h3ED, expErr: 0};
    vecs[1] = '{data: 8'hF4, ackLow: 1'b1, expBits: 10'h2F4, expErr: 0};
    vecs[2] = '{data: 8'hA5, ackLow: 1'b0, expBits: 10'h3A5, expErr: 1};
    vecs[3] = '{data: 8'h01, ackLow: 1'b1, expBits: 10'h201, expErr: 0};

    rstN    = 1'b0;
    txValid = 1'b0;
    txData  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("resetState", int'({txReady, busy, clkDrive, dataDrive, done, ackErr, tmo}),
                int'(7'b1000000));
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      d0 = doneCnt;
      e0 = errCnt;
      applyStimulus(vecs[v].data, vecs[v].ackLow, bits, inh, req);
      repeat (20) @(negedge clk);
      checkOutput($sformatf("inhibitLen[%0d]", v), inh, INH);
      checkOutput($sformatf("reqLen[%0d]", v), req, 1);
      checkOutput($sformatf("frameBits[%0d]", v), int'(bits), int'(vecs[v].expBits));
      checkOutput($sformatf("donePulses[%0d]", v), doneCnt - d0, 1);
      checkOutput($sformatf("ackErrPulses[%0d]", v), errCnt - e0, vecs[v].expErr);
      checkOutput($sformatf("readyAfter[%0d]", v), int'(txReady), 1);
    end

    // Device never clocks: abort exactly TMO cycles after the clock release.
    d0 = doneCnt;
    startFrame(8'h55);
    measureInhibit(0, 8'h00, inh, req);
    cnt = 0;
    for (int i = 0; i < TMO + 50; i++) begin
      @(negedge clk);
      cnt++;
      if (tmo) break;
    end
    checkOutput("timeoutLatency", cnt, TMO);
    checkOutput("timeoutDrives", int'({clkDrive, dataDrive}), 0);
    @(negedge clk);
    checkOutput("timeoutReady", int'(txReady), 1);
    checkOutput("timeoutNoDone", doneCnt - d0, 0);

    // Async reset in the middle of bit 5 (bit4 of 0xED is 0, so data is pulled low).
    startFrame(8'hED);
    measureInhibit(0, 8'h00, inh, req);
    deviceClock(1'b1, 5, bits);
    checkOutput("midFrameDataDrive", int'(dataDrive), 1);
    #2 rstN = 1'b0;
    #1 checkOutput("asyncResetOutputs", int'({clkDrive, dataDrive, txReady, busy}), int'(4'b0010));
    devClkLow  = 1'b0;
    devDataLow = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    d0 = doneCnt;
    applyStimulus(8'hFF, 1'b1, bits, inh, req);
    repeat (20) @(negedge clk);
    checkOutput("postResetBits", int'(bits), int'(10'h3FF));
    checkOutput("postResetDone", doneCnt - d0, 1);

    // Valid held across a frame while the data input changes to 0x00.
    d0 = doneCnt;
    startFrame(8'hF4);
    measureInhibit(1, 8'h00, inh, req);
    deviceClock(1'b1, 0, bits);
    checkOutput("b2bFirstBits", int'(bits), int'(10'h2F4));
    waitClkRise(riseCyc);
    checkOutput("b2bDoneBeforeSecond", doneCnt - d0, 1);
    checkOutput("b2bGap", (riseCyc > lastDoneCyc) ? 1 : 0, 1);
    measureInhibit(0, 8'h00, inh, req);
    deviceClock(1'b1, 0, bits);
    repeat (20) @(negedge clk);
    checkOutput("b2bSecondInhibit", inh, INH);
    checkOutput("b2bSecondBits", int'(bits), int'(10'h300));
    checkOutput("b2bDoneCount", doneCnt - d0, 2);
    checkOutput("b2bIdle", int'({txReady, busy}), int'(2'b10));

    checkOutput("ackErrWithoutDone", errSolo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
